// File: rtl/adder_frame_sequencer.sv
// adder_frame_sequencer: collects a 2*WIDTH/8-byte RX frame into operands A/B,
// launches one add/sub on the external adder, then streams the WIDTH-bit
// result to the UART TX, MSB byte first.
// Optional feature macro: RX_TIMEOUT_EN (abandons a stalled partial frame).
// WIDTH must be a multiple of 8 and at least 16.
module adder_frame_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             sub,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_done,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             cout,
  output logic             rx_status,
  output logic             tx_status,
  output logic             rx_overrun,
  output logic             rx_timeout
);

  localparam int unsigned NBYTES = 2 * WIDTH / 8;
  localparam int unsigned RBYTES = WIDTH / 8;
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam int unsigned TW     = (RBYTES > 1) ? $clog2(RBYTES) : 1;

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT_ADD, TX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [TW-1:0]    tx_idx;
  logic [WIDTH-1:0] result;
  logic             expire;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES);
  logic [IW-1:0] idle;

  // RX silence counter, only running while a partial frame is held
  always_ff @(posedge sys_clk) begin
    if (rst || state != COLLECT || rx_valid || count == '0 || expire)
      idle <= '0;
    else
      idle <= idle + 1'b1;
  end

  always_comb begin
    expire = (state == COLLECT) && (count != '0) && (idle == IW'(TIMEOUT_CYCLES - 1));
  end
`else
  assign expire = 1'b0;
`endif

  // Frame sequencer: collect, launch, wait for adder, transmit result
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= COLLECT;
      count      <= '0;
      tx_idx     <= '0;
      result     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_sub    <= 1'b0;
      add_start  <= 1'b0;
      tx_byte    <= '0;
      tx_valid   <= 1'b0;
      cout       <= 1'b0;
      rx_status  <= 1'b0;
      tx_status  <= 1'b0;
      rx_overrun <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      add_start  <= 1'b0;
      rx_timeout <= 1'b0;
      rx_overrun <= rx_valid && (state != COLLECT);
      case (state)
        COLLECT: begin
          if (rx_valid) begin
            {add_a, add_b} <= {add_a[WIDTH-9:0], add_b, rx_byte};
            if (expire) begin
              // byte arriving on the expiry cycle starts a fresh frame
              count      <= CW'(1);
              rx_status  <= 1'b1;
              rx_timeout <= 1'b1;
            end else if (count == CW'(NBYTES - 1)) begin
              count     <= '0;
              add_sub   <= sub;
              add_start <= 1'b1;
              rx_status <= 1'b0;
              tx_status <= 1'b1;
              state     <= LAUNCH;
            end else begin
              count     <= count + 1'b1;
              rx_status <= 1'b1;
            end
          end else if (expire) begin
            count      <= '0;
            rx_status  <= 1'b0;
            rx_timeout <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT_ADD;
        end
        WAIT_ADD: begin
          if (add_done) begin
            result   <= add_sum;
            cout     <= add_cout;
            tx_byte  <= add_sum[WIDTH-1 -: 8];
            tx_valid <= 1'b1;
            tx_idx   <= '0;
            state    <= TX;
          end
        end
        TX: begin
          if (tx_ready) begin
            if (tx_idx == TW'(RBYTES - 1)) begin
              tx_valid  <= 1'b0;
              tx_status <= 1'b0;
              state     <= COLLECT;
            end else begin
              // result is shifted so the next byte always sits just below the top byte
              tx_idx  <= tx_idx + 1'b1;
              tx_byte <= result[WIDTH-9 -: 8];
              result  <= {result[WIDTH-9:0], 8'h00};
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_frame_sequencer.sv
// Directed bench for adder_frame_sequencer with an external adder model and
// scoreboard queues for launched operands and transmitted result bytes.
module tb_adder_frame_sequencer;

  localparam int W  = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst, sub, rx_valid, add_sub, add_start, add_cout, add_done;
  logic [7:0]    rx_byte, tx_byte;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          tx_valid, tx_ready, cout, rx_status, tx_status, rx_overrun, rx_timeout;

  int total = 0;
  int bad   = 0;

  logic [7:0]    exp_q[$];
  logic [64:0]   op_q[$];
  logic          exp_cout;
  int            starts = 0;
  int            ovr_cycles = 0;
  int            to_pulses = 0;
  int            lat = 1;
  int            cnt = 0;
  bit            hold_en = 1'b1;

  always #5 clk = ~clk;

  adder_frame_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(clk), .rst(rst), .sub(sub), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_start(add_start),
    .add_sum(add_sum), .add_cout(add_cout), .add_done(add_done),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .cout(cout),
    .rx_status(rx_status), .tx_status(tx_status), .rx_overrun(rx_overrun),
    .rx_timeout(rx_timeout)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Adder model: latency 'lat' cycles after add_start
  logic [W-1:0] ma, mb;
  logic         ms;
  always @(negedge clk) begin
    add_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        {add_cout, add_sum} = ms ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};
        if (ms) add_cout = (ma >= mb);
        add_done = 1'b1;
      end
    end
    if (add_start === 1'b1) begin
      starts++;
      ma = add_a; mb = add_b; ms = add_sub;
      cnt = lat;
      total++;
      assert (op_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_start observed=1 expected=0");
      end
      if (op_q.size() != 0) check("operands", {add_sub, add_a, add_b}, op_q.pop_front());
    end
  end

  // TX scoreboard, stall stability and pulse monitors
  logic [7:0] pb;
  logic       pv, pr;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_valid && tx_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_tx observed=%0h expected=none", tx_byte);
        end
        if (exp_q.size() != 0) check("tx_byte", {57'd0, tx_byte}, {57'd0, exp_q.pop_front()});
      end
      if (hold_en && pv === 1'b1 && pr === 1'b0) begin
        check("hold_valid", {64'd0, tx_valid}, 65'd1);
        check("hold_byte", {57'd0, tx_byte}, {57'd0, pb});
      end
      if (rx_overrun) ovr_cycles++;
      if (rx_timeout) to_pulses++;
    end
    pv = tx_valid; pr = tx_ready; pb = tx_byte;
  end

  task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0]   r;
    logic [W-1:0] sum;
    r = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    sum = r[W-1:0];
    exp_cout = s ? (a >= b) : r[W];
    op_q.push_back({s, a, b});
    for (int i = 0; i < W / 8; i++) exp_q.push_back(sum[W-1-8*i -: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] f;
    expect_op(a, b, s);
    sub = s;
    f = {a, b};
    for (int i = 0; i < 2 * W / 8; i++) send_byte(f[2*W-1-8*i -: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (tx_status !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {64'd0, n < 1000}, 65'd1);
    check({tag, "_drained"}, exp_q.size(), 65'd0);
    check({tag, "_cout"}, {64'd0, cout}, {64'd0, exp_cout});
  endtask

  initial begin
    rst = 1'b1; sub = 1'b0; rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    add_done = 1'b0; add_sum = '0; add_cout = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_valid", {64'd0, tx_valid}, 65'd0);
    check("rst_tx_status", {64'd0, tx_status}, 65'd0);
    check("rst_rx_status", {64'd0, rx_status}, 65'd0);
    check("rst_cout", {64'd0, cout}, 65'd0);
    check("rst_operands", {add_sub, add_a, add_b}, 65'd0);

    // 1) simple add
    send_frame(32'd2, 32'd1, 1'b0);
    wait_done("add");
    check("add_starts", starts, 65'd1);

    // 2) subtract with borrow
    send_frame(32'd1, 32'd2, 1'b1);
    wait_done("sub");

    // 3) carry-out result with a 50-cycle TX stall
    tx_ready = 1'b0;
    send_frame(32'hFFFF_FFFF, 32'd2, 1'b0);
    for (int n = 0; n < 100 && tx_valid !== 1'b1; n++) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (50) @(negedge clk);
    tx_ready = 1'b1;
    wait_done("stall");

    // 4) byte during WAIT_ADD is dropped, next frame still decodes
    lat = 20;
    send_frame(32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (5) @(negedge clk);
    send_byte(8'hAA);
    repeat (3) @(negedge clk);
    check("overrun_cycles", ovr_cycles, 65'd1);
    wait_done("ovr_frame");
    lat = 1;
    send_frame(32'd5, 32'd7, 1'b1);
    wait_done("after_ovr");
    check("overrun_final", ovr_cycles, 65'd1);

    // 5) partial frame then silence
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("partial_rx_status", {64'd0, rx_status}, 65'd1);
    repeat (TO + 5) @(negedge clk);
`ifdef RX_TIMEOUT_EN
    check("timeout_pulses", to_pulses, 65'd1);
    check("timeout_rx_status", {64'd0, rx_status}, 65'd0);
    send_frame(32'h0000_000A, 32'h0000_000B, 1'b0);
    wait_done("after_timeout");
`else
    check("no_timeout_pulses", to_pulses, 65'd0);
    check("waiting_rx_status", {64'd0, rx_status}, 65'd1);
    expect_op(32'h0000_0100, 32'h0000_0003, 1'b0);
    sub = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    wait_done("completed_partial");
`endif

    // 6) reset during TX byte 2
    tx_ready = 1'b0;
    send_frame(32'h8000_0000, 32'h8000_0001, 1'b0);
    for (int n = 0; n < 100 && tx_valid !== 1'b1; n++) @(negedge clk);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
    hold_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_valid", {64'd0, tx_valid}, 65'd0);
    check("midrst_tx_status", {64'd0, tx_status}, 65'd0);
    check("midrst_cout", {64'd0, cout}, 65'd0);
    check("midrst_pending", exp_q.size(), 65'd2);
    rst = 1'b0;
    exp_q.delete();
    tx_ready = 1'b1;
    @(negedge clk);
    hold_en = 1'b1;
    send_frame(32'd100, 32'd23, 1'b0);
    wait_done("after_rst");
    check("ops_drained", op_q.size(), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
